imem_fetch_ctrl: RTL
====================

// Module: imem_fetch_ctrl
// PURPOSE
//  Fetch sequencer for the word-addressed instruction memory in the pipelined MIPS core.
//  Owns the PC and drives the memory address each cycle. Returns {instr, pc, valid} to IF/ID.
//  Holds fetch on hazard-unit stall, redirects on branch/jump, traps out-of-range fetches.
// PARAMETERS
//  IMEM_DEPTH  8       number of 32-bit words in instruction memory (valid index 0..IMEM_DEPTH-1)
//  RESET_PC    32'd0   word index fetched first after reset
// PORTS
//  clk              in   1   single clock, rising edge
//  rst              in   1   synchronous, active-high reset
//  stall            in   1   hazard unit: hold IF/ID contents and PC
//  redirect         in   1   branch/jump taken, resolved in EX
//  redirect_target  in   32  word index of new PC
//  address          out  32  instruction-memory address (word index)
//  instruction      in   32  memory read data; valid 1 cycle after address (synchronous read)
//  fetched_instr    out  32  instruction to IF/ID
//  fetched_pc       out  32  word index of fetched_instr
//  fetched_valid    out  1   fetched_instr is real (0 = bubble, IF/ID loads NOP)
//  fault            out  1   sticky out-of-range fetch flag
//  fault_pc         out  32  offending word index
// BEHAVIOUR
//  Reset (rst=1 at edge): pc=RESET_PC, address=RESET_PC, fetched_valid=0, fetched_instr=32'h0,
//   fetched_pc=0, fault=0, fault_pc=0, hold empty, state=IDLE. Reset overrides every other input.
//  States: IDLE -> FETCH (first cycle after reset; request RESET_PC, no output valid);
//   FETCH <-> STALL (on stall); any -> FAULT (out-of-range issue); FAULT exits only by rst.
//  address = pc (combinational from pc register). inflight_valid/inflight_pc registered each issue.
//  FETCH, no stall/redirect: pc<=pc+1; output = instruction/inflight_pc/inflight_valid. Latency 1.
//  stall=1: pc held; first stall cycle captures instruction+inflight_pc into hold reg;
//   fetched_* stay constant for the whole stall. Release: hold reg presented for 1 cycle,
//   pc<=pc+1, memory path resumes next cycle. No instruction dropped or duplicated.
//  redirect=1: highest priority after rst, wins over stall in same cycle: pc<=redirect_target,
//   inflight and hold cleared, fetched_valid=0 next cycle (1-cycle bubble), state=FETCH.
//  Bounds: issuing pc >= IMEM_DEPTH (incl. redirect target, pc wrap past 2^32-1) -> next
//   cycle: state=FAULT, fault=1, fault_pc=pc, fetched_valid=0, pc/address frozen. stall and
//   redirect ignored in FAULT. Instruction already inflight and in range is still delivered.
//  pc arithmetic: 32-bit unsigned, +1 per issue, wraps modulo 2^32 (then faults).
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds outputs perf_fetch_cnt[31:0], perf_stall_cnt[31:0],
//   perf_bubble_cnt[31:0]; count valid deliveries, stall cycles, redirect bubbles; reset to 0,
//   saturate at 32'hFFFF_FFFF, frozen in FAULT.
//  Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared package fetch_pkg: state encodings (IDLE/FETCH/STALL/FAULT, 2 bits), NOP=32'h0,
//   default IMEM_DEPTH.
//  One sub-module: fetch_skid_buf (hold register + mux between memory data and held entry).
// TESTING (memory model: synchronous read, word k = 32'h1000_0000+k, IMEM_DEPTH=8)
//  1 rst 2 cycles, release -> address 0,1,2,3 on successive cycles; fetched_pc 0,1,2 valid
//    from cycle 2; fetched_instr 32'h1000_0000.. in order.
//  2 stall 3 cycles while fetched_pc=2 -> fetched_pc/instr held at 2/32'h1000_0002, address
//    held at 3; after release 3,4,5 delivered, none skipped or repeated.
//  3 redirect target=1 while fetched_pc=4 -> next cycle fetched_valid=0, address=1; then
//    fetched_pc=1 valid with 32'h1000_0001.
//  4 redirect target=6 together with stall -> redirect wins: bubble, then 6 delivered.
//  5 sequential run to pc=8 -> fault=1, fault_pc=8, fetched_valid=0 after word 7 delivered;
//    redirect target=0 ignored; rst clears fault and restarts at 0.
//  6 rst asserted mid-stall with hold full -> all outputs at reset values next cycle,
//    hold empty, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Purpose: shared types and constants for the instruction-fetch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: FSM state encoding, NOP word, default memory depth, fetch entry struct,
//           range check and saturating-increment helpers.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_STALL = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP                = 32'h0000_0000;
  localparam int unsigned DEFAULT_IMEM_DEPTH = 8;

  // One fetched word together with its word index and a real/bubble flag.
  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic pc_in_range(input logic [31:0] pc, input int unsigned depth);
    return pc < 32'(depth);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Purpose: one-entry hold register that parks the word on display when fetch stalls.
// Latency: 0 cycles on the memory path; held entry available the cycle after capture.
// Backpressure: capture on the first stall cycle, present while sel_hold, clear drops the entry.
// Ports: clk/rst (sync, active-high); capture/clear/sel_hold controls;
//        mem_entry (live memory word) in; out_entry (selected word) out.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         capture,
  input  logic         clear,
  input  logic         sel_hold,
  input  fetch_entry_t mem_entry,
  output fetch_entry_t out_entry
);

  fetch_entry_t hold_q;

  // clear wins over capture: a redirect in the same cycle as a stall start
  // must not leave a stale word parked.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hold_q <= '0;
    end else if (capture) begin
      hold_q <= mem_entry;
    end
  end

  assign out_entry = sel_hold ? hold_q : mem_entry;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Purpose: PC owner and fetch sequencer for the word-addressed synchronous instruction memory.
// Latency: 1 cycle from address to fetched_* (memory read latency); 1-cycle bubble after redirect.
// Backpressure: stall holds pc and fetched_*; the held word is replayed on the release cycle.
// Ports: clk, rst (sync, active-high); stall, redirect, redirect_target from hazard/EX;
//        address out / instruction in to memory; fetched_instr/_pc/_valid to IF/ID;
//        fault, fault_pc sticky out-of-range trap.
// Optional: define FETCH_PERF_CNT_EN to add perf_fetch_cnt, perf_stall_cnt, perf_bubble_cnt.
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = DEFAULT_IMEM_DEPTH,
  parameter logic [31:0] RESET_PC   = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] address,
  input  logic [31:0] instruction,
  output logic [31:0] fetched_instr,
  output logic [31:0] fetched_pc,
  output logic        fetched_valid,
  output logic        fault,
  output logic [31:0] fault_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         infl_vld_q, infl_vld_d;
  logic [31:0]  infl_pc_q, infl_pc_d;
  logic         fault_q, fault_d;
  logic [31:0]  fault_pc_q, fault_pc_d;

  logic         hold_capture;
  logic         hold_clear;
  logic         sel_hold;
  fetch_entry_t mem_entry;
  fetch_entry_t out_entry;
  logic         deliver_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      infl_vld_q <= 1'b0;
      infl_pc_q  <= '0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      infl_vld_q <= infl_vld_d;
      infl_pc_q  <= infl_pc_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    infl_vld_d   = 1'b0;
    infl_pc_d    = infl_pc_q;
    fault_d      = fault_q;
    fault_pc_d   = fault_pc_q;
    hold_capture = 1'b0;
    hold_clear   = 1'b0;
    sel_hold     = (state_q == ST_STALL);

    case (state_q)
      ST_FAULT: begin
        // Terminal until rst: everything frozen, nothing issued.
      end
      default: begin
        if (redirect) begin
          // Word being read this cycle belongs to the wrong path: mark it a bubble.
          pc_d       = redirect_target;
          hold_clear = 1'b1;
          state_d    = ST_FETCH;
        end else if (!pc_in_range(pc_q, IMEM_DEPTH)) begin
          // Word already inflight is shown this cycle; the trap lands next cycle.
          state_d    = ST_FAULT;
          fault_d    = 1'b1;
          fault_pc_d = pc_q;
          hold_clear = 1'b1;
        end else if (stall) begin
          // Memory keeps re-reading the same pc, so the inflight tag stays accurate.
          state_d      = ST_STALL;
          hold_capture = (state_q != ST_STALL);
          infl_vld_d   = 1'b1;
          infl_pc_d    = pc_q;
        end else begin
          // On the stall release cycle the held word is shown, then dropped.
          state_d    = ST_FETCH;
          pc_d       = pc_q + 32'd1;
          infl_vld_d = 1'b1;
          infl_pc_d  = pc_q;
          hold_clear = (state_q == ST_STALL);
        end
      end
    endcase
  end

  assign mem_entry = '{vld: infl_vld_q, pc: infl_pc_q, instr: instruction};

  fetch_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .capture   (hold_capture),
    .clear     (hold_clear),
    .sel_hold  (sel_hold),
    .mem_entry (mem_entry),
    .out_entry (out_entry)
  );

  // Bubbles present NOP/0 so IF/ID never sees stale memory data.
  assign deliver_vld   = out_entry.vld && (state_q != ST_FAULT);
  assign fetched_valid = deliver_vld;
  assign fetched_instr = deliver_vld ? out_entry.instr : NOP;
  assign fetched_pc    = deliver_vld ? out_entry.pc : 32'd0;
  assign address       = pc_q;
  assign fault         = fault_q;
  assign fault_pc      = fault_pc_q;

`ifdef FETCH_PERF_CNT_EN
  // A delivery is a real word shown in a cycle the consumer is not stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt  <= '0;
      perf_stall_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else if (state_q != ST_FAULT) begin
      if (deliver_vld && !stall) begin
        perf_fetch_cnt <= sat_inc(perf_fetch_cnt);
      end
      if (stall) begin
        perf_stall_cnt <= sat_inc(perf_stall_cnt);
      end
      if (redirect) begin
        perf_bubble_cnt <= sat_inc(perf_bubble_cnt);
      end
    end
  end
`endif

endmodule
